instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 16, width of the program counter and the instruction-memory address.
REQ-002 Parameter RESET_PC, default 0, program counter value loaded on reset.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, synchronous and active-low.
REQ-005 mem_req  output  1  instruction-memory read request.
REQ-006 mem_addr  output  ADDR_W  read address; equals pc while mem_req=1.
REQ-007 mem_ack  input  1  memory has placed the read data on mem_data this cycle.
REQ-008 mem_data  input  32  instruction word from memory.
REQ-009 instruction  output  32  instruction word presented to the control unit.
REQ-010 instr_valid  output  1  instruction holds a fetched word not yet accepted.
REQ-011 instr_ready  input  1  control unit accepts instruction this cycle.
REQ-012 pcControl  input  1  branch taken for the accepted instruction.
REQ-013 branch_target  input  ADDR_W  next pc when pcControl=1.
REQ-014 pc  output  ADDR_W  address of the word currently being fetched or held.
REQ-015 halted  output  1  HLT accepted; fetching stopped.
REQ-016 icount  output  32  number of instructions accepted since reset.

Function
REQ-017 The opcode SHALL be instruction[31:26]; HLT = 6'd29, NOP = 6'd28.
REQ-018 The FSM SHALL have three states: FETCH, HOLD, HALT.
REQ-019 In FETCH, mem_req=1, mem_addr=pc and instr_valid=0.
REQ-020 In FETCH, on mem_ack=1, the block SHALL latch mem_data into instruction and enter HOLD. instr_valid=1 and mem_req=0 on the next cycle.
REQ-021 Fetch latency SHALL be exactly one cycle from the mem_ack edge to instr_valid=1. Zero-wait memory gives one instruction per 2 cycles.
REQ-022 In HOLD, instruction and pc SHALL stay stable until instr_ready=1, and mem_req=0 throughout.
REQ-023 In HOLD with instr_ready=1, icount SHALL increment by 1 and wrap from 2^32-1 to 0.
REQ-024 In HOLD with instr_ready=1 and opcode==HLT, the block SHALL enter HALT. pc is unchanged and pcControl is ignored.
REQ-025 In HOLD with instr_ready=1 and opcode!=HLT, the block SHALL enter FETCH:
- pcControl=1: pc <= branch_target.
- pcControl=0: pc <= pc+1, modulo 2^ADDR_W (all-ones wraps to 0).
REQ-026 pcControl and branch_target SHALL be ignored in every cycle except HOLD with instr_ready=1.
REQ-027 mem_ack SHALL be ignored outside FETCH.
REQ-028 instr_ready SHALL be ignored outside HOLD.
REQ-029 In HALT, halted=1, mem_req=0 and instr_valid=0. instruction keeps the HLT word. Only reset exits HALT.
REQ-030 The block SHALL never have mem_req=1 and instr_valid=1 in the same cycle.

Reset
REQ-031 When resetn=0 at a rising edge, all of the following SHALL hold on the next cycle, regardless of state:
- state = FETCH.
- pc = RESET_PC.
- instruction = {6'd28,26'd0} (NOP).
- instr_valid = 0, halted = 0, icount = 0.
REQ-032 While resetn=0, mem_req SHALL be driven 0 combinationally, so no request is issued during reset.
REQ-033 A reset that arrives mid-fetch or during HOLD SHALL discard the pending word. A mem_ack in the reset cycle SHALL be ignored.
REQ-034 On the first cycle after resetn returns to 1, the block SHALL be in FETCH with mem_req=1 and mem_addr=RESET_PC.

Verification
REQ-035 Sequential fetch: zero-wait memory and instr_ready tied to 1, words at addresses 0..3 are 0x00000000..0x00000003 -> those words are accepted in order at a 2-cycle cadence; pc reads 0,1,2,3; icount=4.
REQ-036 Branch: instr_ready=1 with pcControl=1 and branch_target=16'h0040 while at pc=5 -> next mem_addr=16'h0040. pcControl=1 pulsed during FETCH -> no effect.
REQ-037 Backpressure: instr_ready=0 for 5 cycles -> instruction, pc and instr_valid stay stable, mem_req=0, icount unchanged; the word is accepted on the cycle instr_ready rises.
REQ-038 Halt: word 0x74000000 (opcode 29) at pc=2 is accepted -> halted=1 next cycle, mem_req stays 0 for 20 cycles, pc=2, icount=3.
REQ-039 Wrap and reset: ADDR_W=4 at pc=15 with a non-branch word accepted -> pc=0. resetn=0 asserted while waiting for mem_ack, with mem_ack=1 in that same cycle -> instruction=0x70000000, instr_valid=0, pc=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit.
//
// Fetches one 32-bit word at a time from instruction memory at address pc, holds it for the
// control unit until accepted, then advances pc (sequentially or to a branch target). An
// accepted HLT word stops fetching until reset.
//
// Ports:
//   clock          single clock, rising-edge
//   resetn         synchronous active-low reset
//   mem_req        instruction-memory read request
//   mem_addr       read address (always pc)
//   mem_ack        read data valid on mem_data this cycle
//   mem_data       instruction word from memory
//   instruction    word presented to the control unit
//   instr_valid    instruction holds a fetched, not-yet-accepted word
//   instr_ready    control unit accepts instruction this cycle
//   pcControl      branch taken for the accepted instruction
//   branch_target  next pc when pcControl is set
//   pc             address of the word being fetched or held
//   halted         HLT accepted, fetching stopped
//   icount         number of accepted instructions since reset (wraps)
module instruction_fetch #(
  parameter int unsigned        ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clock,
  input  logic              resetn,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pcControl,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       icount
);

  localparam logic [5:0]  OpHlt   = 6'd29;
  localparam logic [5:0]  OpNop   = 6'd28;
  localparam logic [31:0] NopWord = {OpNop, 26'd0};

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StHalt
  } state_e;

  state_e state;

  logic [5:0] opcode;
  assign opcode = instruction[31:26];

  // Gated by resetn so no request escapes while reset is held, whatever the state register holds.
  assign mem_req  = resetn && (state == StFetch);
  assign mem_addr = pc;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= StFetch;
      pc          <= RESET_PC;
      instruction <= NopWord;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      icount      <= '0;
    end else begin
      unique case (state)
        StFetch: begin
          if (mem_ack) begin
            instruction <= mem_data;
            instr_valid <= 1'b1;
            state       <= StHold;
          end
        end
        StHold: begin
          if (instr_ready) begin
            icount      <= icount + 32'd1;
            instr_valid <= 1'b0;
            if (opcode == OpHlt) begin
              // pc stays on the HLT word; branch inputs are not consulted.
              halted <= 1'b1;
              state  <= StHalt;
            end else begin
              pc    <= pcControl ? branch_target : pc + ADDR_W'(1);
              state <= StFetch;
            end
          end
        end
        StHalt: begin
          // Only reset leaves this state.
        end
        default: begin
          state <= StFetch;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] word;
  } accept_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_control;
  logic [15:0] branch_target;
  logic [15:0] pc;
  logic        halted;
  logic [31:0] icount;

  // Second instance with a 4-bit pc for the wrap case.
  logic        resetn4;
  logic        mem_req4;
  logic [3:0]  mem_addr4;
  logic        mem_ack4;
  logic [31:0] mem_data4;
  logic [31:0] instruction4;
  logic        instr_valid4;
  logic        instr_ready4;
  logic        pc_control4;
  logic [3:0]  branch_target4;
  logic [3:0]  pc4;
  logic        halted4;
  logic [31:0] icount4;

  logic [31:0] mem [256];
  logic        ack_en;
  logic        ack_force;
  logic        mon_en;

  accept_t     exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  // Zero-wait memory model; ack_force drives mem_ack regardless of mem_req.
  assign mem_ack  = (mem_req & ack_en) | ack_force;
  assign mem_data = mem[mem_addr[7:0]];

  instruction_fetch #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) u_dut (
    .clock         (clk),
    .resetn        (resetn),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pcControl     (pc_control),
    .branch_target (branch_target),
    .pc            (pc),
    .halted        (halted),
    .icount        (icount)
  );

  instruction_fetch #(
    .ADDR_W   (4),
    .RESET_PC (4'd0)
  ) u_dut4 (
    .clock         (clk),
    .resetn        (resetn4),
    .mem_req       (mem_req4),
    .mem_addr      (mem_addr4),
    .mem_ack       (mem_ack4),
    .mem_data      (mem_data4),
    .instruction   (instruction4),
    .instr_valid   (instr_valid4),
    .instr_ready   (instr_ready4),
    .pcControl     (pc_control4),
    .branch_target (branch_target4),
    .pc            (pc4),
    .halted        (halted4),
    .icount        (icount4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] p, input logic [31:0] w);
    accept_t e;
    e.pc   = p;
    e.word = w;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every accepted word is popped and compared against the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      check("req_and_valid", {63'd0, mem_req & instr_valid}, 64'd0);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept", 64'd1, 64'd0);
        end else begin
          accept_t e;
          e = exp_q.pop_front();
          check("accept_word", {32'd0, instruction}, {32'd0, e.word});
          check("accept_pc", {48'd0, pc}, {48'd0, e.pc});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) mem[i] = i;
    resetn = 1'b0; ack_en = 1'b0; ack_force = 1'b0; mon_en = 1'b0;
    instr_ready = 1'b0; pc_control = 1'b0; branch_target = '0;
    resetn4 = 1'b0; mem_ack4 = 1'b0; mem_data4 = '0; instr_ready4 = 1'b0;
    pc_control4 = 1'b0; branch_target4 = '0;

    // Reset state
    tick(2);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_icount", {32'd0, icount}, 64'd0);
    check("rst_pc", {48'd0, pc}, 64'd0);
    check("rst_instr", {32'd0, instruction}, 64'h7000_0000);
    resetn = 1'b1;
    #1;
    check("post_rst_req", {63'd0, mem_req}, 64'd1);
    check("post_rst_addr", {48'd0, mem_addr}, 64'd0);
    mon_en = 1'b1;

    // Sequential fetch, zero-wait, always ready
    for (int i = 0; i < 4; i++) push(16'(i), 32'(i));
    ack_en = 1'b1; instr_ready = 1'b1;
    cyc = 0;
    while (icount != 32'd4 && cyc < 20) begin
      tick(1);
      cyc++;
    end
    ack_en = 1'b0; instr_ready = 1'b0;
    check("seq_icount", {32'd0, icount}, 64'd4);
    check("seq_cycles", 64'(cyc), 64'd8);
    check("seq_pc", {48'd0, pc}, 64'd4);

    // Branch
    push(16'd4, 32'd4);
    ack_en = 1'b1; instr_ready = 1'b1;
    tick(2);
    ack_en = 1'b0; instr_ready = 1'b0;
    check("br_pc5", {48'd0, pc}, 64'd5);
    pc_control = 1'b1; branch_target = 16'h0080;
    tick(2);
    check("br_fetch_ignore_pc", {48'd0, pc}, 64'd5);
    check("br_fetch_ignore_addr", {48'd0, mem_addr}, 64'd5);
    ack_en = 1'b1;
    tick(1);
    ack_en = 1'b0;
    check("br_hold_pc", {48'd0, pc}, 64'd5);
    check("br_hold_valid", {63'd0, instr_valid}, 64'd1);
    branch_target = 16'h0040; instr_ready = 1'b1;
    push(16'd5, 32'd5);
    tick(1);
    instr_ready = 1'b0; pc_control = 1'b0;
    check("br_target_addr", {48'd0, mem_addr}, 64'h40);
    check("br_target_req", {63'd0, mem_req}, 64'd1);
    check("br_icount", {32'd0, icount}, 64'd6);

    // Backpressure
    ack_en = 1'b1;
    tick(1);
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {63'd0, instr_valid}, 64'd1);
      check("bp_req", {63'd0, mem_req}, 64'd0);
      check("bp_instr", {32'd0, instruction}, 64'h40);
      check("bp_pc", {48'd0, pc}, 64'h40);
      check("bp_icount", {32'd0, icount}, 64'd6);
      tick(1);
    end
    push(16'h0040, 32'h40);
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    check("bp_accept_icount", {32'd0, icount}, 64'd7);
    check("bp_accept_valid", {63'd0, instr_valid}, 64'd0);

    // Halt at pc=2
    resetn = 1'b0;
    tick(1);
    mem[2] = 32'h7400_0000;
    push(16'd0, 32'd0); push(16'd1, 32'd1); push(16'd2, 32'h7400_0000);
    resetn = 1'b1; ack_en = 1'b1; instr_ready = 1'b1;
    cyc = 0;
    while (!halted && cyc < 20) begin
      tick(1);
      cyc++;
    end
    check("hlt_cycles", 64'(cyc), 64'd6);
    check("hlt_halted", {63'd0, halted}, 64'd1);
    check("hlt_icount", {32'd0, icount}, 64'd3);
    check("hlt_instr", {32'd0, instruction}, 64'h7400_0000);
    pc_control = 1'b1; branch_target = 16'h0033;
    for (int i = 0; i < 20; i++) begin
      check("hlt_req", {63'd0, mem_req}, 64'd0);
      check("hlt_valid", {63'd0, instr_valid}, 64'd0);
      check("hlt_pc", {48'd0, pc}, 64'd2);
      tick(1);
    end
    pc_control = 1'b0; ack_en = 1'b0; instr_ready = 1'b0;
    check("hlt_icount_end", {32'd0, icount}, 64'd3);

    // Reset while waiting for mem_ack, with mem_ack in the reset cycle
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(1);
    check("rf_wait_req", {63'd0, mem_req}, 64'd1);
    resetn = 1'b0; ack_force = 1'b1;
    #1;
    check("rf_req_in_reset", {63'd0, mem_req}, 64'd0);
    tick(1);
    ack_force = 1'b0;
    check("rf_instr", {32'd0, instruction}, 64'h7000_0000);
    check("rf_valid", {63'd0, instr_valid}, 64'd0);
    check("rf_pc", {48'd0, pc}, 64'd0);
    check("rf_halted", {63'd0, halted}, 64'd0);
    check("rf_icount", {32'd0, icount}, 64'd0);

    // Reset during HOLD discards the held word
    resetn = 1'b1; ack_en = 1'b1;
    mem[0] = 32'h1234_5678;
    tick(1);
    ack_en = 1'b0;
    check("rh_valid_before", {63'd0, instr_valid}, 64'd1);
    check("rh_instr_before", {32'd0, instruction}, 64'h1234_5678);
    resetn = 1'b0;
    tick(1);
    check("rh_valid", {63'd0, instr_valid}, 64'd0);
    check("rh_instr", {32'd0, instruction}, 64'h7000_0000);
    resetn = 1'b1;
    #1;
    check("rh_req", {63'd0, mem_req}, 64'd1);

    // ADDR_W=4 pc wrap
    resetn4 = 1'b1; mem_ack4 = 1'b1; mem_data4 = 32'h0000_0011;
    tick(1);
    mem_ack4 = 1'b0; instr_ready4 = 1'b1; pc_control4 = 1'b1; branch_target4 = 4'd15;
    tick(1);
    instr_ready4 = 1'b0; pc_control4 = 1'b0;
    check("w4_pc15", {60'd0, pc4}, 64'd15);
    check("w4_addr15", {60'd0, mem_addr4}, 64'd15);
    mem_ack4 = 1'b1; mem_data4 = 32'h0000_0022;
    tick(1);
    mem_ack4 = 1'b0;
    check("w4_instr", {32'd0, instruction4}, 64'h22);
    instr_ready4 = 1'b1;
    tick(1);
    instr_ready4 = 1'b0;
    check("w4_pc_wrap", {60'd0, pc4}, 64'd0);
    check("w4_addr_wrap", {60'd0, mem_addr4}, 64'd0);
    check("w4_req", {63'd0, mem_req4}, 64'd1);
    check("w4_valid", {63'd0, instr_valid4}, 64'd0);
    check("w4_halted", {63'd0, halted4}, 64'd0);
    check("w4_icount", {32'd0, icount4}, 64'd2);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
